// File: rtl/wshb_arbiter_rr.sv
// Wishbone N:1 arbiter (round-robin or fixed priority); grant registered, held for the whole cyc.
// One-cycle grant latency, zero-latency combinational data/ack path; losers stall with no ack.
module wshb_arbiter_rr #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int ARB_MODE    = 0,
    parameter int TIMEOUT     = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_MASTERS-1:0]              s_cyc,
    input  logic [NUM_MASTERS-1:0]              s_stb,
    input  logic [NUM_MASTERS-1:0]              s_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   s_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   s_dat_ms,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] s_sel,
    input  logic [NUM_MASTERS*3-1:0]            s_cti,
    input  logic [NUM_MASTERS*2-1:0]            s_bte,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]   s_dat_sm,
    output logic [NUM_MASTERS-1:0]              s_ack,
    output logic [NUM_MASTERS-1:0]              s_err,
    output logic                                m_cyc,
    output logic                                m_stb,
    output logic                                m_we,
    output logic [ADDR_WIDTH-1:0]               m_adr,
    output logic [DATA_WIDTH-1:0]               m_dat_ms,
    output logic [DATA_WIDTH/8-1:0]             m_sel,
    output logic [2:0]                          m_cti,
    output logic [1:0]                          m_bte,
    input  logic [DATA_WIDTH-1:0]               m_dat_sm,
    input  logic                                m_ack,
    input  logic                                m_err,
    output logic [NUM_MASTERS-1:0]              gnt
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W     = $clog2(NUM_MASTERS);
    localparam int WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        FLUSH   = 2'd2
    } arbStateT;

    arbStateT         state, stateNext;
    logic [IDX_W-1:0] gntIdx, gntIdxNext;
    logic [IDX_W-1:0] lastIdx, lastIdxNext;
    logic [WD_W-1:0]  wdCnt, wdCntNext;
    logic [IDX_W-1:0] winner;
    logic [IDX_W:0]   candSum;
    logic [IDX_W-1:0] candIdx;
    logic             grantedCyc;
    logic             grantedStb;
    logic             timeoutHit;

    assign grantedCyc = s_cyc[gntIdx];
    assign grantedStb = s_stb[gntIdx];
    assign s_dat_sm   = {NUM_MASTERS{m_dat_sm}};

    // Built from the requester's own stb so it does not loop through the m_* mux.
    assign timeoutHit = (TIMEOUT > 0) && (state == GRANTED) && (wdCnt == WD_LAST)
                        && grantedStb && !m_ack;

    // Scans run backwards so the last hit is the first requester in scan order.
    always_comb begin
        winner  = '0;
        candSum = '0;
        candIdx = '0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (s_cyc[i]) winner = IDX_W'(i);
            end
        end else begin
            for (int k = NUM_MASTERS; k >= 1; k--) begin
                candSum = {1'b0, lastIdx} + (IDX_W+1)'(k);
                if (candSum >= (IDX_W+1)'(NUM_MASTERS))
                    candSum = candSum - (IDX_W+1)'(NUM_MASTERS);
                candIdx = candSum[IDX_W-1:0];
                if (s_cyc[candIdx]) winner = candIdx;
            end
        end
    end

    always_comb begin
        stateNext   = state;
        gntIdxNext  = gntIdx;
        lastIdxNext = lastIdx;
        wdCntNext   = '0;
        case (state)
            IDLE: begin
                if (|s_cyc) begin
                    gntIdxNext = winner;
                    stateNext  = GRANTED;
                end
            end
            GRANTED: begin
                if (!grantedCyc) begin
                    lastIdxNext = gntIdx;
                    stateNext   = IDLE;
                end else if (timeoutHit) begin
                    stateNext = FLUSH;
                end else if ((TIMEOUT > 0) && grantedStb && !m_ack && !m_err) begin
                    wdCntNext = wdCnt + 1'b1;
                end
            end
            FLUSH: begin
                if (!grantedCyc) begin
                    lastIdxNext = gntIdx;
                    stateNext   = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gntIdx  <= '0;
            lastIdx <= IDX_W'(NUM_MASTERS - 1);
            wdCnt   <= '0;
        end else begin
            state   <= stateNext;
            gntIdx  <= gntIdxNext;
            lastIdx <= lastIdxNext;
            wdCnt   <= wdCntNext;
        end
    end

    always_comb begin
        m_cyc    = 1'b0;
        m_stb    = 1'b0;
        m_we     = 1'b0;
        m_adr    = '0;
        m_dat_ms = '0;
        m_sel    = '0;
        m_cti    = '0;
        m_bte    = '0;
        s_ack    = '0;
        s_err    = '0;
        gnt      = '0;
        if (state == GRANTED) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (gntIdx == IDX_W'(i)) begin
                    m_cyc    = s_cyc[i];
                    m_stb    = s_stb[i];
                    m_we     = s_we[i];
                    m_adr    = s_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    m_dat_ms = s_dat_ms[i*DATA_WIDTH +: DATA_WIDTH];
                    m_sel    = s_sel[i*SEL_WIDTH +: SEL_WIDTH];
                    m_cti    = s_cti[i*3 +: 3];
                    m_bte    = s_bte[i*2 +: 2];
                    s_ack[i] = m_ack;
                    s_err[i] = m_err | timeoutHit;
                    gnt[i]   = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wshb_arbiter_rr.sv
// Directed bench: 3-port round-robin arbiter with 16-cycle watchdog, plus a 3-port priority arbiter.
module tb_wshb_arbiter_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin instance, TIMEOUT=16
    logic        aRst;
    logic [2:0]  aCyc, aStb, aWe;
    logic [95:0] aAdr, aDatMs;
    logic [11:0] aSel;
    logic [8:0]  aCti;
    logic [5:0]  aBte;
    logic [95:0] aDatSm;
    logic [2:0]  aAck, aErr, aGnt;
    logic        aMCyc, aMStb, aMWe;
    logic [31:0] aMAdr, aMDatMs, aMDatSm;
    logic [3:0]  aMSel;
    logic [2:0]  aMCti;
    logic [1:0]  aMBte;
    logic        aMAck, aMErr;

    // Fixed-priority instance, watchdog off
    logic        bRst;
    logic [2:0]  bCyc, bStb, bWe;
    logic [95:0] bAdr, bDatMs;
    logic [11:0] bSel;
    logic [8:0]  bCti;
    logic [5:0]  bBte;
    logic [95:0] bDatSm;
    logic [2:0]  bAck, bErr, bGnt;
    logic        bMCyc, bMStb, bMWe;
    logic [31:0] bMAdr, bMDatMs, bMDatSm;
    logic [3:0]  bMSel;
    logic [2:0]  bMCti;
    logic [1:0]  bMBte;
    logic        bMAck, bMErr;

    int nChecks = 0;
    int nFails  = 0;

    logic [2:0]  expGnt, expAck, expErr;
    logic        expMcyc;
    logic [31:0] expAdr;

    wshb_arbiter_rr #(.NUM_MASTERS(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .ARB_MODE(0), .TIMEOUT(16)) dutRr (
        .clk(clk), .rst(aRst),
        .s_cyc(aCyc), .s_stb(aStb), .s_we(aWe), .s_adr(aAdr), .s_dat_ms(aDatMs),
        .s_sel(aSel), .s_cti(aCti), .s_bte(aBte), .s_dat_sm(aDatSm),
        .s_ack(aAck), .s_err(aErr),
        .m_cyc(aMCyc), .m_stb(aMStb), .m_we(aMWe), .m_adr(aMAdr), .m_dat_ms(aMDatMs),
        .m_sel(aMSel), .m_cti(aMCti), .m_bte(aMBte), .m_dat_sm(aMDatSm),
        .m_ack(aMAck), .m_err(aMErr), .gnt(aGnt)
    );

    wshb_arbiter_rr #(.NUM_MASTERS(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .ARB_MODE(1), .TIMEOUT(0)) dutPri (
        .clk(clk), .rst(bRst),
        .s_cyc(bCyc), .s_stb(bStb), .s_we(bWe), .s_adr(bAdr), .s_dat_ms(bDatMs),
        .s_sel(bSel), .s_cti(bCti), .s_bte(bBte), .s_dat_sm(bDatSm),
        .s_ack(bAck), .s_err(bErr),
        .m_cyc(bMCyc), .m_stb(bMStb), .m_we(bMWe), .m_adr(bMAdr), .m_dat_ms(bMDatMs),
        .m_sel(bMSel), .m_cti(bMCti), .m_bte(bMBte), .m_dat_sm(bMDatSm),
        .m_ack(bMAck), .m_err(bMErr), .gnt(bGnt)
    );

    task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        aRst = 1'b1; aCyc = 3'b111; aStb = 3'b000; aWe = 3'b000;
        aAdr = {32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
        aDatMs = {32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
        aSel = 12'hFFF; aCti = '0; aBte = '0;
        aMDatSm = '0; aMAck = 1'b0; aMErr = 1'b0;
        bRst = 1'b1; bCyc = 3'b000; bStb = 3'b000; bWe = 3'b000;
        bAdr = {32'h0000_B200, 32'h0000_B100, 32'h0000_B000};
        bDatMs = '0; bSel = 12'hFFF; bCti = '0; bBte = '0;
        bMDatSm = '0; bMAck = 1'b0; bMErr = 1'b0;

        // Reset held over two edges with every requester asserting cyc
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            checkVal($sformatf("rst_mcyc[%0d]", r), aMCyc, 1'b0);
            checkVal($sformatf("rst_gnt[%0d]", r), aGnt, 3'b000);
        end
        nextCycle();
        aRst = 1'b0;

        // Round-robin: each master drops cyc for one cycle after a 4-beat burst
        for (int c = 0; c <= 20; c++) begin
            aCyc  = {c != 17, c != 11, c != 5};
            aStb  = aCyc;
            aMAck = (c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16) || (c >= 19);
            expGnt = (c >= 1 && c <= 5)   ? 3'b001 :
                     (c >= 7 && c <= 11)  ? 3'b010 :
                     (c >= 13 && c <= 17) ? 3'b100 :
                     (c >= 19)            ? 3'b001 : 3'b000;
            expMcyc = (expGnt != 3'b000) && (c != 5) && (c != 11) && (c != 17);
            expAck  = expGnt & {3{aMAck}};
            expAdr  = (expGnt == 3'b010) ? 32'h0000_1000 :
                      (expGnt == 3'b100) ? 32'h0000_2000 : 32'h0000_0000;
            @(negedge clk);
            checkVal($sformatf("rr_gnt[%0d]", c), aGnt, expGnt);
            checkVal($sformatf("rr_mcyc[%0d]", c), aMCyc, expMcyc);
            checkVal($sformatf("rr_ack[%0d]", c), aAck, expAck);
            checkVal($sformatf("rr_adr[%0d]", c), aMAdr, expAdr);
            nextCycle();
        end

        // Reset asserted while master 0 owns the bus
        aCyc = 3'b111; aStb = 3'b111; aMAck = 1'b0; aRst = 1'b1;
        @(negedge clk);
        checkVal("midrst_mcyc_before", aMCyc, 1'b1);
        nextCycle();
        @(negedge clk);
        checkVal("midrst_mcyc_after", aMCyc, 1'b0);
        checkVal("midrst_gnt_after", aGnt, 3'b000);
        aCyc = 3'b000; aStb = 3'b000;
        nextCycle();
        aRst = 1'b0;

        // 8-beat incrementing burst from master 0 while master 1 waits
        aMDatSm = 32'hDEAD_BEEF;
        for (int d = 0; d <= 11; d++) begin
            aCyc  = {1'b0, 1'b1, d <= 8};
            aStb  = aCyc;
            aCti  = {3'b000, 3'b000, (d == 8) ? 3'b111 : 3'b010};
            aMAck = (d <= 8);
            expGnt = (d >= 1 && d <= 9) ? 3'b001 : (d == 11) ? 3'b010 : 3'b000;
            expMcyc = (d >= 1 && d <= 8) || (d == 11);
            expAck  = (d >= 1 && d <= 8) ? 3'b001 : 3'b000;
            @(negedge clk);
            checkVal($sformatf("burst_gnt[%0d]", d), aGnt, expGnt);
            checkVal($sformatf("burst_mcyc[%0d]", d), aMCyc, expMcyc);
            checkVal($sformatf("burst_ack[%0d]", d), aAck, expAck);
            if (d >= 1 && d <= 8)
                checkVal($sformatf("burst_cti[%0d]", d), aMCti, (d == 8) ? 3'b111 : 3'b010);
            if (d == 4)
                checkVal("bcast_dat", aDatSm, {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
            nextCycle();
        end

        // Watchdog: master 0 stalls with no ack, master 1 waits behind it
        aCti = '0; aMAck = 1'b0;
        for (int w = 0; w <= 24; w++) begin
            aCyc = {1'b0, w != 0, w <= 21};
            aStb = aCyc;
            expGnt = (w == 0 || w == 24) ? 3'b010 : (w >= 2 && w <= 17) ? 3'b001 : 3'b000;
            expErr = (w == 17) ? 3'b001 : 3'b000;
            expMcyc = (w >= 2 && w <= 17) || (w == 24);
            @(negedge clk);
            checkVal($sformatf("wd_gnt[%0d]", w), aGnt, expGnt);
            checkVal($sformatf("wd_err[%0d]", w), aErr, expErr);
            checkVal($sformatf("wd_mcyc[%0d]", w), aMCyc, expMcyc);
            nextCycle();
        end

        // Fixed priority: masters 1 and 2 request continuously, 1 always wins
        bRst = 1'b0;
        for (int e = 0; e <= 11; e++) begin
            bCyc  = {1'b1, !(e == 3 || e == 8), 1'b0};
            bStb  = bCyc;
            bMErr = (e == 6);
            expGnt  = (e == 0 || e == 4 || e == 9) ? 3'b000 : 3'b010;
            expMcyc = (expGnt != 3'b000) && bCyc[1];
            expErr  = (e == 6) ? 3'b010 : 3'b000;
            @(negedge clk);
            checkVal($sformatf("pri_gnt[%0d]", e), bGnt, expGnt);
            checkVal($sformatf("pri_mcyc[%0d]", e), bMCyc, expMcyc);
            checkVal($sformatf("pri_err[%0d]", e), bErr, expErr);
            if (expGnt != 3'b000)
                checkVal($sformatf("pri_adr[%0d]", e), bMAdr, 32'h0000_B100);
            nextCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
